// File: rtl/pxi_rd_port_if.sv
// Acquisition-side push interface for pxi_rd_port.
// Defining PXI_RD_UNDERRUN_EN adds the sticky underrun flag to the bundle.
interface pxi_rd_port_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]   src_data;
  logic          src_valid;
  logic          src_ready;
  logic [CW-1:0] fifo_count;
`ifdef PXI_RD_UNDERRUN_EN
  logic          underrun;
`endif

  modport master (
    output src_data, src_valid,
`ifdef PXI_RD_UNDERRUN_EN
    input  underrun,
`endif
    input  src_ready, fifo_count
  );

  modport slave (
    input  src_data, src_valid,
`ifdef PXI_RD_UNDERRUN_EN
    output underrun,
`endif
    output src_ready, fifo_count
  );
endinterface

// File: rtl/pxi_rd_port.sv
// PXI host read port: FIFO of acquisition words presented on a tri-state bus per host strobe.
// Optional PXI_RD_UNDERRUN_EN: sticky underrun flag and 16'h8000 empty-read word.
module pxi_rd_port #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] datain,
  input  logic        data_en,
  pxi_rd_port_if.slave src
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_POP   = 2'd2;

`ifdef PXI_RD_UNDERRUN_EN
  localparam logic [15:0] EMPTY_WORD = 16'h8000;
`else
  localparam logic [15:0] EMPTY_WORD = 16'h0000;
`endif

  // Strobe synchronizer and edge detect
  logic       r_sync1, r_rd_s, r_rd_prev, r_armed;
  logic [1:0] r_vld_pipe;
  logic       w_rd_start, w_rd_end;

  // After reset, a rise only counts once rd_s has been seen low with the
  // synchronizer refilled; a strobe held across reset must not restart a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_rd_s     <= 1'b0;
      r_rd_prev  <= 1'b0;
      r_vld_pipe <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_sync1    <= data_en;
      r_rd_s     <= r_sync1;
      r_rd_prev  <= r_rd_s;
      r_vld_pipe <= {r_vld_pipe[0], 1'b1};
      if (r_vld_pipe[1] && !r_rd_s) r_armed <= 1'b1;
    end
  end

  assign w_rd_start = r_rd_s & ~r_rd_prev & r_armed;
  assign w_rd_end   = ~r_rd_s & r_rd_prev;

  // FIFO storage
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic [15:0]   r_out;
  logic          r_hit;
  logic          w_empty, w_ready, w_push, w_pop;

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count < FULL_CNT);
  assign w_push  = src.src_valid & w_ready;
  assign w_pop   = (r_state == S_POP) & r_hit;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= src.src_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read FSM: the word is captured at rd_start so later pushes cannot disturb it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_hit   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_rd_start) begin
          r_out   <= w_empty ? EMPTY_WORD : r_mem[r_rptr];
          r_hit   <= ~w_empty;
          r_state <= S_DRIVE;
        end
        S_DRIVE: if (w_rd_end) r_state <= S_POP;
        S_POP: begin
          r_hit   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PXI_RD_UNDERRUN_EN
  logic r_underrun;

  always_ff @(posedge clk) begin
    if (rst)                                          r_underrun <= 1'b0;
    else if (r_state == S_IDLE && w_rd_start && w_empty) r_underrun <= 1'b1;
  end

  assign src.underrun = r_underrun;
`endif

  assign datain         = (r_state == S_DRIVE) ? r_out : 16'hzzzz;
  assign src.src_ready  = w_ready;
  assign src.fifo_count = r_count;
endmodule

// File: tb/tb_pxi_rd_port.sv
// Scoreboard bench for pxi_rd_port: directed pushes/reads, a monitor checks every bus word.
// Released bus is seen as 16'hFFFF through pullups; build with PXI_RD_UNDERRUN_EN to test the option.
module tb_pxi_rd_port;
  localparam int DEPTH = 16;
`ifdef PXI_RD_UNDERRUN_EN
  localparam logic [15:0] EMPTY_W = 16'h8000;
`else
  localparam logic [15:0] EMPTY_W = 16'h0000;
`endif
  localparam logic [15:0] FLOAT_W = 16'hFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_en = 1'b0;
  wire [15:0] datain;

  pxi_rd_port_if #(.DEPTH(DEPTH)) sif ();

  pxi_rd_port #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .data_en (data_en),
    .src     (sif)
  );

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup pu (datain[g]);
  end

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  bit prev_drv = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: each new bus drive must match the oldest expected word
  always @(negedge clk) begin
    logic        drv;
    logic [15:0] e;
    drv = (datain !== FLOAT_W);
    if (drv && !prev_drv) begin
      if (exp_q.size() == 0) chk("unexpected_drive", datain, FLOAT_W);
      else begin
        e = exp_q.pop_front();
        chk("bus_word", datain, e);
      end
    end
    prev_drv = drv;
  end

  task automatic push(input logic [15:0] w);
    @(negedge clk);
    sif.src_data  = w;
    sif.src_valid = 1'b1;
    @(negedge clk);
    sif.src_valid = 1'b0;
  endtask

  // Host read with strobe high for 'hold' clk edges; optional push landing on the POP cycle
  task automatic host_read(input int hold, input logic [15:0] exp_w,
                           input bit do_push, input logic [15:0] pw);
    exp_q.push_back(exp_w);
    @(negedge clk);
    data_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("pre_drive", datain, FLOAT_W);
    @(posedge clk);
    #1 chk("drive_3rd_edge", datain, exp_w);
    repeat (hold - 3) @(posedge clk);
    @(negedge clk);
    data_en = 1'b0;
    repeat (3) @(posedge clk);
    if (do_push) begin
      @(negedge clk);
      sif.src_data  = pw;
      sif.src_valid = 1'b1;
    end
    @(posedge clk);
    #1 chk("release_4th_edge", datain, FLOAT_W);
    if (do_push) begin
      @(negedge clk);
      sif.src_valid = 1'b0;
    end
  endtask

  function automatic logic [15:0] cnt();
    return 16'(sif.fifo_count);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    sif.src_data  = '0;
    sif.src_valid = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", cnt(), 16'd0);
    chk("rst_ready", 16'(sif.src_ready), 16'd1);
    chk("rst_bus", datain, FLOAT_W);
`ifdef PXI_RD_UNDERRUN_EN
    chk("rst_underrun", 16'(sif.underrun), 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Two words, two reads
    push(16'h1234);
    push(16'h5678);
    chk("two_push_count", cnt(), 16'd2);
    host_read(6, 16'h1234, 1'b0, 16'h0);
    chk("after_read1_count", cnt(), 16'd1);
    host_read(6, 16'h5678, 1'b0, 16'h0);
    chk("after_read2_count", cnt(), 16'd0);

    // Empty read
    host_read(4, EMPTY_W, 1'b0, 16'h0);
    chk("empty_read_count", cnt(), 16'd0);
`ifdef PXI_RD_UNDERRUN_EN
    chk("underrun_set", 16'(sif.underrun), 16'd1);
`endif

    // Fill past full: 17th word must be dropped
    for (int i = 1; i <= 17; i++) begin
      push(16'h0100 + 16'(i));
      if (i == 16) begin
        chk("full_ready_low", 16'(sif.src_ready), 16'd0);
        chk("full_count", cnt(), 16'd16);
      end
    end
    chk("overflow_count", cnt(), 16'd16);
    for (int i = 1; i <= 16; i++) host_read(3, 16'h0100 + 16'(i), 1'b0, 16'h0);
    chk("drain_count", cnt(), 16'd0);
    chk("drain_ready", 16'(sif.src_ready), 16'd1);

    // Push coinciding with POP at count 3
    push(16'hA001);
    push(16'hA002);
    push(16'hA003);
    chk("pp_pre_count", cnt(), 16'd3);
    host_read(4, 16'hA001, 1'b1, 16'hA004);
    chk("pp_count_held", cnt(), 16'd3);
    host_read(4, 16'hA002, 1'b0, 16'h0);
    host_read(4, 16'hA003, 1'b0, 16'h0);
    host_read(4, 16'hA004, 1'b0, 16'h0);
    chk("pp_drain_count", cnt(), 16'd0);

    // Reset during DRIVE, strobe held high across reset
    push(16'hB001);
    exp_q.push_back(16'hB001);
    @(negedge clk);
    data_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("rst_drive_word", datain, 16'hB001);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_drive_release", datain, FLOAT_W);
    chk("rst_drive_count", cnt(), 16'd0);
`ifdef PXI_RD_UNDERRUN_EN
    chk("rst_drive_underrun", 16'(sif.underrun), 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (datain !== FLOAT_W) seen = 1'b1;
    end
    chk("no_drive_after_rst", 16'(seen), 16'd0);
    @(negedge clk);
    data_en = 1'b0;
    repeat (4) @(posedge clk);
    push(16'hC001);
    host_read(4, 16'hC001, 1'b0, 16'h0);
    chk("post_rst_count", cnt(), 16'd0);

    // One-clock strobe pulse
    push(16'hD001);
    push(16'hD002);
    exp_q.push_back(16'hD001);
    @(negedge clk);
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pulse_release", datain, FLOAT_W);
    chk("pulse_count", cnt(), 16'd1);
    repeat (3) @(posedge clk);
    host_read(4, 16'hD002, 1'b0, 16'h0);
    chk("pulse_drain_count", cnt(), 16'd0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
